// File: rtl/avl_bridge_pkg.sv
// Shared types and constants for the Avalon-MM command pipeline bridge.
package avl_bridge_pkg;

    localparam int AVL_ADDR_W = 26;
    localparam int AVL_DATA_W = 128;
    localparam int AVL_SIZE_W = 8;

    // Bit positions inside err_flags
    localparam int ERR_UNEXP_RDV = 0;
    localparam int ERR_RW_BOTH   = 1;

    // One buffered command; is_write=0 means read
    typedef struct packed {
        logic [AVL_ADDR_W-1:0] address;
        logic [AVL_DATA_W-1:0] writedata;
        logic [AVL_SIZE_W-1:0] size;
        logic                  burstbegin;
        logic                  is_write;
    } avl_cmd_t;

    // A zero burst size still moves one beat
    function automatic logic [AVL_SIZE_W:0] burst_beats(input logic [AVL_SIZE_W-1:0] size);
        return (size == '0) ? (AVL_SIZE_W + 1)'(1) : {1'b0, size};
    endfunction

endpackage

// File: rtl/avl_skid_buf.sv
// Two-entry valid/ready skid register. M drives the output, K catches the
// one command that arrives while M is stalled. The upstream stall is a
// register, so no combinational path runs from out_ready_i to in_ready_o.
module avl_skid_buf
    import avl_bridge_pkg::*;
#(
    parameter type T = avl_cmd_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid_i,
    input  T     in_data_i,
    output logic in_ready_o,
    output logic out_valid_o,
    output T     out_data_o,
    input  logic out_ready_i
);

    logic m_valid_q, m_valid_d;
    logic k_valid_q, k_valid_d;
    T     m_data_q, m_data_d;
    T     k_data_q, k_data_d;
    logic wait_q;
    logic accept;
    logic issue;

    assign accept      = in_valid_i & ~wait_q;
    assign issue       = m_valid_q & out_ready_i;
    assign in_ready_o  = ~wait_q;
    assign out_valid_o = m_valid_q;
    assign out_data_o  = m_data_q;

    // Next-state of the two slots: K refills M on issue, otherwise new data lands in the free slot
    always_comb begin
        m_valid_d = m_valid_q;
        k_valid_d = k_valid_q;
        m_data_d  = m_data_q;
        k_data_d  = k_data_q;
        if (issue) begin
            if (k_valid_q) begin
                m_data_d  = k_data_q;
                k_valid_d = 1'b0;
            end else if (accept) begin
                m_data_d  = in_data_i;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!m_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data_i;
            end else begin
                k_valid_d = 1'b1;
                k_data_d  = in_data_i;
            end
        end
    end

    // Slot registers; stall comes up during reset and then tracks K occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_valid_q <= 1'b0;
            k_valid_q <= 1'b0;
            m_data_q  <= '0;
            k_data_q  <= '0;
            wait_q    <= 1'b1;
        end else begin
            m_valid_q <= m_valid_d;
            k_valid_q <= k_valid_d;
            m_data_q  <= m_data_d;
            k_data_q  <= k_data_d;
            wait_q    <= k_valid_d;
        end
    end

endmodule

// File: rtl/avl_cmd_pipe_bridge.sv
// Registered Avalon-MM bridge between the DDR3 RW test master and the
// controller port: skid-buffered command path, read-beat credit limiter,
// registered read return and sticky protocol error flags.
// A read burst larger than MAX_RD_PENDING can never be issued, so the
// master must keep its burst sizes within that limit.
module avl_cmd_pipe_bridge
    import avl_bridge_pkg::*;
#(
    parameter int ADDR_W         = AVL_ADDR_W,
    parameter int DATA_W         = AVL_DATA_W,
    parameter int SIZE_W         = AVL_SIZE_W,
    parameter int MAX_RD_PENDING = 16,
    parameter int CNT_W          = 5
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [ADDR_W-1:0] s_address,
    input  logic [DATA_W-1:0] s_writedata,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [SIZE_W-1:0] s_size,
    input  logic              s_burstbegin,
    output logic              s_waitrequest,
    output logic [DATA_W-1:0] s_readdata,
    output logic              s_readdatavalid,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_read,
    output logic              m_write,
    output logic [SIZE_W-1:0] m_size,
    output logic              m_burstbegin,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    output logic [CNT_W-1:0]  rd_pending,
    output logic [1:0]        err_flags
);

    // Wide enough to hold rd_pending + beats without wrapping
    localparam int SUM_W = ((CNT_W > SIZE_W + 1) ? CNT_W : SIZE_W + 1) + 1;

    avl_cmd_t          cmd_in;
    avl_cmd_t          cmd_m;
    logic              cmd_in_valid;
    logic              cmd_in_ready;
    logic              m_valid;
    logic              cmd_ready;
    logic [SIZE_W:0]   m_beats;
    logic [SUM_W-1:0]  credit_sum;
    logic              rd_block;
    logic              rd_issue;
    logic [CNT_W-1:0]  rd_pending_q, rd_pending_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rdv_q;

    // A simultaneous read+write is forwarded as a write
    always_comb begin
        cmd_in.address    = s_address;
        cmd_in.writedata  = s_writedata;
        cmd_in.size       = s_size;
        cmd_in.burstbegin = s_burstbegin;
        cmd_in.is_write   = s_write;
    end

    assign cmd_in_valid  = s_read | s_write;
    assign s_waitrequest = ~cmd_in_ready;

    avl_skid_buf #(
        .T (avl_cmd_t)
    ) u_skid (
        .clk_i       (iCLK),
        .rst_ni      (iRST_n),
        .in_valid_i  (cmd_in_valid),
        .in_data_i   (cmd_in),
        .in_ready_o  (cmd_in_ready),
        .out_valid_o (m_valid),
        .out_data_o  (cmd_m),
        .out_ready_i (cmd_ready)
    );

    // Hold a read in M while its beats would overflow the controller read FIFO
    assign m_beats    = burst_beats(cmd_m.size);
    assign credit_sum = SUM_W'(rd_pending_q) + SUM_W'(m_beats);
    assign rd_block   = m_valid & ~cmd_m.is_write & (credit_sum > SUM_W'(MAX_RD_PENDING));
    assign cmd_ready  = ~m_waitrequest & ~rd_block;
    assign rd_issue   = m_valid & ~cmd_m.is_write & cmd_ready;

    assign m_address    = cmd_m.address;
    assign m_writedata  = cmd_m.writedata;
    assign m_size       = cmd_m.size;
    assign m_burstbegin = cmd_m.burstbegin;
    assign m_write      = m_valid & cmd_m.is_write;
    assign m_read       = m_valid & ~cmd_m.is_write & ~rd_block;

    // Pending-beat counter and sticky error flags; a stray readdatavalid leaves the count at zero
    always_comb begin
        rd_pending_d = rd_pending_q;
        err_d        = err_q;
        if (rd_issue) begin
            rd_pending_d = rd_pending_d + CNT_W'(m_beats);
        end
        if (m_readdatavalid) begin
            if (rd_pending_q == '0) begin
                err_d[ERR_UNEXP_RDV] = 1'b1;
            end else begin
                rd_pending_d = rd_pending_d - CNT_W'(1);
            end
        end
        if (s_read && s_write) begin
            err_d[ERR_RW_BOTH] = 1'b1;
        end
    end

    // Credit, error and read-return registers
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rd_pending_q <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
            rdv_q        <= 1'b0;
        end else begin
            rd_pending_q <= rd_pending_d;
            err_q        <= err_d;
            rdata_q      <= m_readdata;
            rdv_q        <= m_readdatavalid;
        end
    end

    assign rd_pending      = rd_pending_q;
    assign err_flags       = err_q;
    assign s_readdata      = rdata_q;
    assign s_readdatavalid = rdv_q;

endmodule
